if_stage: RTL and testbench

- Instruction-fetch stage with the IF/ID pipeline register of the 5-stage MIPS pipeline.
- Owns the PC, drives the instruction-memory request and selects the next PC (PC+4, taken branch, jump).
- Presents InsID/PCplus4ID to the ID stage, hazard unit and branch comparator.
- Consumes PC_hold/IFID_hold from hazard detection, plus branch/jump redirects resolved in ID. No branch delay slot: the instruction fetched behind a taken redirect is squashed.

---
 rtl/if_stage.sv | 83 ++++++++
 tb/tb_if_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage owning the PC, the imem request and the IF/ID register.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        PC_hold,
  input  logic        IFID_hold,
  input  logic        ifBranch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] PC_IF,
  output logic [31:0] InsID,
  output logic [31:0] PCplus4ID,
  output logic        validID
);
  typedef enum logic {BOOT, RUN} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ins_q, ins_d, p4_q, p4_d, ptgt_q, ptgt_d, target;
  logic        valid_q, valid_d, pend_q, pend_d, redir, load;
  always_comb begin
    redir   = jump | ifBranch;
    target  = (jump ? jump_target : branch_target) & ~32'h3;
    state_d = RUN;
    pc_d    = pc_q;
    pend_d  = pend_q;
    ptgt_d  = ptgt_q;
    load    = 1'b0;
    // A redirect seen while a fetch is stalled is parked until the memory completes
    if (state_q == RUN) begin
      if (pend_q) begin
        if (imem_ready) begin
          pc_d   = ptgt_q;
          pend_d = 1'b0;
        end
      end else if (!PC_hold) begin
        if (redir) begin
          if (imem_ready) pc_d = target;
          else begin
            pend_d = 1'b1;
            ptgt_d = target;
          end
        end else if (imem_ready) begin
          pc_d = pc_q + 32'd4;
          load = 1'b1;
        end
      end
    end
    ins_d   = IFID_hold ? ins_q : (load ? imem_rdata : 32'h0);
    p4_d    = (IFID_hold || !load) ? p4_q : pc_q + 32'd4;
    valid_d = IFID_hold ? valid_q : load;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ins_q   <= 32'h0;
      p4_q    <= 32'h0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      ptgt_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      p4_q    <= p4_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      ptgt_q  <= ptgt_d;
    end
  end
  assign imem_req  = (state_q == RUN);
  assign imem_addr = pc_q;
  assign PC_IF     = pc_q;
  assign InsID     = ins_q;
  assign PCplus4ID = p4_q;
  assign validID   = valid_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and randomized checks of if_stage against a behavioural fetch model.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        PC_hold = 1'b0, IFID_hold = 1'b0, ifBranch = 1'b0, jump = 1'b0, imem_ready = 1'b1;
  logic [31:0] branch_target = 32'h0, jump_target = 32'h0;
  logic        imem_req, validID;
  logic [31:0] imem_addr, imem_rdata, PC_IF, InsID, PCplus4ID;
  int          pass_cnt = 0, total_cnt = 0;
  logic        m_boot, m_pend, m_valid;
  logic [31:0] m_pc, m_ptgt, m_ins, m_p4;

  if_stage dut (
    .clk(clk), .reset_n(reset_n), .PC_hold(PC_hold), .IFID_hold(IFID_hold),
    .ifBranch(ifBranch), .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .PC_IF(PC_IF), .InsID(InsID), .PCplus4ID(PCplus4ID), .validID(validID)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign imem_rdata = imem_ready ? mem(imem_addr) : 32'hDEAD_BEEF;

  task automatic model_reset();
    m_boot = 1'b1; m_pend = 1'b0; m_valid = 1'b0;
    m_pc = 32'h0; m_ptgt = 32'h0; m_ins = 32'h0; m_p4 = 32'h0;
  endtask

  // Advance one clock: derive the model's next state from this cycle's inputs, then sample at negedge.
  task automatic cyc();
    logic [31:0] npc, nptgt, dest;
    logic        npend, fetched;
    npc = m_pc; nptgt = m_ptgt; npend = m_pend; fetched = 1'b0;
    dest = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
    if (!m_boot) begin
      if (m_pend) begin
        if (imem_ready) begin npc = m_ptgt; npend = 1'b0; end
      end else if (!PC_hold && (jump || ifBranch)) begin
        if (imem_ready) npc = dest;
        else begin npend = 1'b1; nptgt = dest; end
      end else if (!PC_hold && imem_ready) begin
        npc = m_pc + 32'd4;
        fetched = 1'b1;
      end
    end
    @(posedge clk);
    if (!IFID_hold) begin
      m_valid = fetched;
      m_ins = fetched ? mem(m_pc) : 32'h0;
      if (fetched) m_p4 = m_pc + 32'd4;
    end
    m_pc = npc; m_ptgt = nptgt; m_pend = npend; m_boot = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle();
    PC_hold = 1'b0; IFID_hold = 1'b0; ifBranch = 1'b0; jump = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic goto(input logic [31:0] a);
    jump = 1'b1; jump_target = a; cyc(); jump = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    #1 reset_n = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    total_cnt++; if (PC_IF !== 32'h0) $display("FAIL rst_pc got %h want %h", PC_IF, 32'h0); else pass_cnt++;
    total_cnt++; if ({validID, InsID, PCplus4ID} !== 65'h0) $display("FAIL rst_ifid got %b %h %h want 0", validID, InsID, PCplus4ID); else pass_cnt++;
    reset_n = 1'b1;
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL boot_req got %b want 0", imem_req); else pass_cnt++;
    cyc();
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL run_first got req=%b addr=%h want 1 0", imem_req, imem_addr); else pass_cnt++;
    cyc();
    total_cnt++; if (imem_addr !== 32'h4) $display("FAIL seq_addr4 got %h want 4", imem_addr); else pass_cnt++;
    total_cnt++; if (InsID !== mem(32'h0) || PCplus4ID !== 32'h4 || validID !== 1'b1) $display("FAIL seq_ifid0 got %h %h %b want %h 4 1", InsID, PCplus4ID, validID, mem(32'h0)); else pass_cnt++;
    cyc();
    total_cnt++; if (imem_addr !== 32'h8) $display("FAIL seq_addr8 got %h want 8", imem_addr); else pass_cnt++;
  endtask

  task automatic test_hold();
    cyc(); cyc();
    PC_hold = 1'b1; IFID_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      total_cnt++; if (imem_addr !== 32'h10) $display("FAIL hold_addr got %h want 10", imem_addr); else pass_cnt++;
      total_cnt++; if (InsID !== mem(32'hC) || PCplus4ID !== 32'h10 || validID !== 1'b1) $display("FAIL hold_ifid got %h %h %b want %h 10 1", InsID, PCplus4ID, validID, mem(32'hC)); else pass_cnt++;
    end
    idle();
    cyc();
    total_cnt++; if (imem_addr !== 32'h14 || InsID !== mem(32'h10) || PCplus4ID !== 32'h14) $display("FAIL hold_release got %h %h %h want 14 %h 14", imem_addr, InsID, PCplus4ID, mem(32'h10)); else pass_cnt++;
  endtask

  task automatic test_branch();
    goto(32'hC);
    ifBranch = 1'b1; branch_target = 32'h40;
    cyc();
    ifBranch = 1'b0;
    total_cnt++; if (imem_addr !== 32'h40 || InsID !== 32'h0 || validID !== 1'b0) $display("FAIL br_redirect got %h %h %b want 40 0 0", imem_addr, InsID, validID); else pass_cnt++;
    cyc();
    total_cnt++; if (InsID !== mem(32'h40) || validID !== 1'b1 || PCplus4ID !== 32'h44) $display("FAIL br_target_ins got %h %b %h want %h 1 44", InsID, validID, PCplus4ID, mem(32'h40)); else pass_cnt++;
  endtask

  task automatic test_jump_priority();
    jump = 1'b1; jump_target = 32'h103; ifBranch = 1'b1; branch_target = 32'h40;
    cyc();
    idle();
    total_cnt++; if (PC_IF !== 32'h100) $display("FAIL jump_wins got %h want 100", PC_IF); else pass_cnt++;
  endtask

  task automatic test_pending();
    goto(32'h20);
    ifBranch = 1'b1; branch_target = 32'h80; imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      branch_target = 32'h200;
      total_cnt++; if (imem_addr !== 32'h20 || validID !== 1'b0) $display("FAIL pend_wait got %h %b want 20 0", imem_addr, validID); else pass_cnt++;
    end
    idle();
    cyc();
    total_cnt++; if (imem_addr !== 32'h80 || validID !== 1'b0) $display("FAIL pend_apply got %h %b want 80 0", imem_addr, validID); else pass_cnt++;
    cyc();
    total_cnt++; if (InsID !== mem(32'h80) || validID !== 1'b1) $display("FAIL pend_ins got %h %b want %h 1", InsID, validID, mem(32'h80)); else pass_cnt++;
  endtask

  task automatic test_wrap_async_reset();
    goto(32'hFFFF_FFFC);
    cyc();
    total_cnt++; if (PC_IF !== 32'h0 || PCplus4ID !== 32'h0 || InsID !== mem(32'hFFFF_FFFC)) $display("FAIL wrap got %h %h %h want 0 0 %h", PC_IF, PCplus4ID, InsID, mem(32'hFFFF_FFFC)); else pass_cnt++;
    cyc();
    ifBranch = 1'b1; branch_target = 32'h300; imem_ready = 1'b0;
    cyc();
    idle();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    total_cnt++; if (PC_IF !== 32'h0 || validID !== 1'b0 || imem_req !== 1'b0) $display("FAIL async_rst got %h %b %b want 0 0 0", PC_IF, validID, imem_req); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    cyc(); cyc();
    total_cnt++; if (PC_IF !== 32'h4) $display("FAIL pend_lost got %h want 4", PC_IF); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      PC_hold = ($urandom_range(0, 3) == 0);
      IFID_hold = ($urandom_range(0, 4) == 0);
      ifBranch = ($urandom_range(0, 5) == 0);
      jump = ($urandom_range(0, 7) == 0);
      branch_target = $urandom;
      jump_target = $urandom;
      imem_ready = ($urandom_range(0, 2) != 0);
      cyc();
      total_cnt++; if (PC_IF !== m_pc || imem_addr !== m_pc || imem_req !== 1'b1) $display("FAIL rnd_pc[%0d] got %h %h %b want %h", i, PC_IF, imem_addr, imem_req, m_pc); else pass_cnt++;
      total_cnt++; if (InsID !== m_ins || PCplus4ID !== m_p4 || validID !== m_valid) $display("FAIL rnd_ifid[%0d] got %h %h %b want %h %h %b", i, InsID, PCplus4ID, validID, m_ins, m_p4, m_valid); else pass_cnt++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_hold();
    test_branch();
    test_jump_priority();
    test_pending();
    test_wrap_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
